// File: rtl/result_checker_if.sv
// Bundle of shadow-write, golden-ROM and report signals for result_checker.
// The slave modport is the checker; the master modport is the processor/bench side.
interface result_checker_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 18
);
   localparam int NB = DATA_W / 8;

   logic              wen;
   logic [29:0]       addr;
   logic [DATA_W-1:0] wdata;
   logic [NB-1:0]     wbe;
   logic [31:0]       pc;
   logic              done;
   logic              gold_rd;
   logic [ADDR_W-1:0] gold_addr;
   logic [DATA_W-1:0] gold_data;
   logic [ADDR_W:0]   error_num;
   logic [ADDR_W-1:0] first_err_addr;
   logic              first_err_vld;
   logic [CNT_W-1:0]  duration;
   logic              timeout;
   logic              late_wr;
   logic              finish;

   modport slave (
      input  wen, addr, wdata, wbe, pc, done, gold_data,
      output gold_rd, gold_addr, error_num, first_err_addr, first_err_vld,
             duration, timeout, late_wr, finish
   );

   modport master (
      output wen, addr, wdata, wbe, pc, done, gold_data,
      input  gold_rd, gold_addr, error_num, first_err_addr, first_err_vld,
             duration, timeout, late_wr, finish
   );
endinterface

// File: rtl/result_checker.sv
// End-of-run checker: shadows the D-cache write stream, then compares the
// shadow array word by word against a golden ROM and reports the outcome.
module result_checker #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int END_PC  = 400,
   parameter int MODE    = 0,
   parameter int TIMEOUT = 250000,
   parameter int CNT_W   = 18
) (
   input  logic            clk,
   input  logic            rst,
   result_checker_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NB    = DATA_W / 8;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      CHECK = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [DATA_W-1:0] shadow_r [DEPTH];
   logic              trig_s;
   logic              wdog_s;
   logic              in_range_s;
   logic              last_s;
   logic              gold_rd_r;
   logic [ADDR_W-1:0] gold_addr_r;
   logic              cmp_vld_r;
   logic [ADDR_W-1:0] cmp_addr_r;
   logic [ADDR_W:0]   error_num_r;
   logic [ADDR_W-1:0] first_err_addr_r;
   logic              first_err_vld_r;
   logic [CNT_W-1:0]  duration_r;
   logic              timeout_r;
   logic              late_wr_r;
   logic              finish_r;

   // End-of-program, watchdog, address-range and last-index decode.
   always_comb begin
      trig_s     = 1'b0;
      wdog_s     = (duration_r == CNT_W'(TIMEOUT));
      in_range_s = (bus.addr < 30'(DEPTH));
      last_s     = (gold_addr_r == ADDR_W'(DEPTH - 1));
      if (MODE == 0) begin
         trig_s = (bus.pc >= 32'(END_PC));
      end else begin
         trig_s = bus.done;
      end
   end

   // Next-state logic; the end-of-program trigger and the watchdog both leave RUN.
   always_comb begin
      state_s = state_r;
      case (state_r)
         RUN: begin
            if (trig_s || wdog_s) state_s = CHECK;
            else                  state_s = RUN;
         end
         CHECK: begin
            if (last_s) state_s = DRAIN;
            else        state_s = CHECK;
         end
         DRAIN:   state_s = DONE;
         DONE:    state_s = DONE;
         default: state_s = RUN;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= RUN;
      else      state_r <= state_s;
   end

   // Shadow array has no reset so that contents loaded during reset survive it.
   always_ff @(posedge clk) begin
      if ((state_r == RUN) && bus.wen && in_range_s) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.wbe[b]) shadow_r[bus.addr[ADDR_W-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end

   // Read sequencing, compare stage one cycle behind gold_rd, and report registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gold_rd_r        <= 1'b0;
         gold_addr_r      <= '0;
         cmp_vld_r        <= 1'b0;
         cmp_addr_r       <= '0;
         error_num_r      <= '0;
         first_err_addr_r <= '0;
         first_err_vld_r  <= 1'b0;
         duration_r       <= '0;
         timeout_r        <= 1'b0;
         late_wr_r        <= 1'b0;
         finish_r         <= 1'b0;
      end else begin
         cmp_vld_r  <= gold_rd_r;
         cmp_addr_r <= gold_addr_r;
         case (state_r)
            RUN: begin
               if (trig_s) begin
                  gold_rd_r <= 1'b1;
               end else if (wdog_s) begin
                  gold_rd_r <= 1'b1;
                  timeout_r <= 1'b1;
               end else if (duration_r != {CNT_W{1'b1}}) begin
                  duration_r <= duration_r + CNT_W'(1);
               end
            end
            CHECK: begin
               if (last_s) gold_rd_r   <= 1'b0;
               else        gold_addr_r <= gold_addr_r + ADDR_W'(1);
            end
            DRAIN:   finish_r <= 1'b0;
            DONE:    finish_r <= 1'b1;
            default: finish_r <= 1'b0;
         endcase
         // Full-word 4-state compare; an X in the shadow counts as a mismatch.
         if (cmp_vld_r && (shadow_r[cmp_addr_r] !== bus.gold_data)) begin
            error_num_r <= error_num_r + (ADDR_W + 1)'(1);
            if (!first_err_vld_r) begin
               first_err_addr_r <= cmp_addr_r;
               first_err_vld_r  <= 1'b1;
            end
         end
         if (bus.wen && (state_r != RUN)) late_wr_r <= 1'b1;
      end
   end

   assign bus.gold_rd        = gold_rd_r;
   assign bus.gold_addr      = gold_addr_r;
   assign bus.error_num      = error_num_r;
   assign bus.first_err_addr = first_err_addr_r;
   assign bus.first_err_vld  = first_err_vld_r;
   assign bus.duration       = duration_r;
   assign bus.timeout        = timeout_r;
   assign bus.late_wr        = late_wr_r;
   assign bus.finish         = finish_r;
endmodule

// File: tb/tb_result_checker.sv
// Directed bench: MODE 0 instance (256 words, PC trigger) and MODE 1 instance
// (16 words, TIMEOUT 50) with a behavioural 1-cycle-latency golden ROM each.
module tb_result_checker;
   logic clk = 1'b0;
   logic rst0;
   logic rst1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   result_checker_if #(.ADDR_W(8), .DATA_W(32), .CNT_W(18)) b0 ();
   result_checker_if #(.ADDR_W(4), .DATA_W(32), .CNT_W(8))  b1 ();

   result_checker #(.ADDR_W(8), .DATA_W(32), .END_PC(400), .MODE(0),
                    .TIMEOUT(250000), .CNT_W(18))
      dut0 (.clk(clk), .rst(rst0), .bus(b0.slave));

   result_checker #(.ADDR_W(4), .DATA_W(32), .END_PC(400), .MODE(1),
                    .TIMEOUT(50), .CNT_W(8))
      dut1 (.clk(clk), .rst(rst1), .bus(b1.slave));

   function automatic logic [31:0] gold_word(input logic [7:0] a);
      return {8'hC0 ^ a, a, 8'h5A, ~a};
   endfunction

   always @(posedge clk) begin
      if (b0.gold_rd) b0.gold_data <= gold_word(b0.gold_addr);
      if (b1.gold_rd) b1.gold_data <= gold_word({4'h0, b1.gold_addr});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put0(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
      b0.wen = 1'b1; b0.addr = a; b0.wdata = d; b0.wbe = be;
   endtask

   // Releases dut0 reset at a negedge and runs RUN for trig cycles, then
   // raises pc; returns at the negedge right after the trigger edge.
   task automatic start0(input int trig, input bit corrupt);
      b0.pc = 32'd0;
      rst0  = 1'b1;
      for (int c = 1; c <= trig; c++) begin
         @(negedge clk);
         b0.wen = 1'b0;
         if (c == 10)               b0.pc = 32'd399;
         if (!corrupt && c == 20)   put0(30'd3, gold_word(8'd3), 4'b0101);
         if (!corrupt && c == 30)   put0(30'd255, gold_word(8'd255), 4'b1111);
         if (corrupt && c == 10)    put0(30'd5, 32'hFFFF_FFFF, 4'b0010);
         if (corrupt && c == 20)    put0(30'd256, 32'h0000_0000, 4'b1111);
      end
      b0.pc = 32'd400;
      if (corrupt) put0(30'd200, 32'hFFFF_FFFF, 4'b0010);
      @(negedge clk);
      b0.wen = 1'b0;
   endtask

   initial begin
      rst0 = 1'b0; rst1 = 1'b0;
      b0.wen = 1'b0; b0.addr = 30'd0; b0.wdata = 32'd0; b0.wbe = 4'd0;
      b0.pc = 32'd0; b0.done = 1'b0; b0.gold_data = 32'd0;
      b1.wen = 1'b0; b1.addr = 30'd0; b1.wdata = 32'd0; b1.wbe = 4'd0;
      b1.pc = 32'd0; b1.done = 1'b0; b1.gold_data = 32'd0;
      #1;
      check("rst_gold_rd",  64'(b0.gold_rd), 64'd0);
      check("rst_error",    64'(b0.error_num), 64'd0);
      check("rst_duration", 64'(b0.duration), 64'd0);
      check("rst_finish",   64'(b0.finish), 64'd0);

      // Preload both shadows with golden data while held in reset.
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         put0(30'(i), gold_word(8'(i)), 4'b1111);
         b1.wen = (i < 16); b1.addr = 30'(i); b1.wdata = gold_word(8'(i)); b1.wbe = 4'b1111;
      end
      @(negedge clk);
      b0.wen = 1'b0; b1.wen = 1'b0;

      // Run 1: golden-identical writes, trigger at cycle 1000.
      start0(1000, 1'b0);
      check("r1_gold_rd0",   64'(b0.gold_rd), 64'd1);
      check("r1_gold_addr0", 64'(b0.gold_addr), 64'd0);
      repeat (257) @(negedge clk);
      check("r1_finish_early", 64'(b0.finish), 64'd0);
      @(negedge clk);
      check("r1_finish",    64'(b0.finish), 64'd1);
      check("r1_error",     64'(b0.error_num), 64'd0);
      check("r1_first_vld", 64'(b0.first_err_vld), 64'd0);
      check("r1_duration",  64'(b0.duration), 64'd1000);
      check("r1_timeout",   64'(b0.timeout), 64'd0);
      check("r1_late_wr",   64'(b0.late_wr), 64'd0);
      check("r1_gold_rd",   64'(b0.gold_rd), 64'd0);

      // Run 2: partial-write corruption of words 5 and 200, out-of-range and late writes.
      rst0 = 1'b0;
      @(negedge clk);
      start0(600, 1'b1);
      repeat (5) @(negedge clk);
      put0(30'd250, 32'h0000_0000, 4'b1111);
      @(negedge clk);
      b0.wen = 1'b0;
      repeat (252) @(negedge clk);
      check("r2_finish",     64'(b0.finish), 64'd1);
      check("r2_error",      64'(b0.error_num), 64'd2);
      check("r2_first_addr", 64'(b0.first_err_addr), 64'd5);
      check("r2_first_vld",  64'(b0.first_err_vld), 64'd1);
      check("r2_late_wr",    64'(b0.late_wr), 64'd1);
      check("r2_duration",   64'(b0.duration), 64'd600);

      // Run 3: reset asserted while the walk is at index 100.
      rst0 = 1'b0;
      @(negedge clk);
      start0(600, 1'b1);
      repeat (100) @(negedge clk);
      check("r3_gold_addr100", 64'(b0.gold_addr), 64'd100);
      check("r3_error_mid",    64'(b0.error_num), 64'd1);
      rst0 = 1'b0;
      #1;
      check("r3_rst_gold_rd",   64'(b0.gold_rd), 64'd0);
      check("r3_rst_gold_addr", 64'(b0.gold_addr), 64'd0);
      check("r3_rst_error",     64'(b0.error_num), 64'd0);
      check("r3_rst_first",     64'({b0.first_err_vld, b0.first_err_addr}), 64'd0);
      check("r3_rst_duration",  64'(b0.duration), 64'd0);
      check("r3_rst_flags",     64'({b0.timeout, b0.late_wr, b0.finish}), 64'd0);

      // Run 4: rerun after the interrupted check reports the run-2 results.
      @(negedge clk);
      start0(600, 1'b1);
      repeat (258) @(negedge clk);
      check("r4_finish",     64'(b0.finish), 64'd1);
      check("r4_error",      64'(b0.error_num), 64'd2);
      check("r4_first_addr", 64'(b0.first_err_addr), 64'd5);
      check("r4_duration",   64'(b0.duration), 64'd600);
      check("r4_late_wr",    64'(b0.late_wr), 64'd0);

      // MODE 1 run A: done never raised, watchdog fires at duration 50.
      rst1 = 1'b1;
      repeat (50) @(negedge clk);
      check("ma_duration_run", 64'(b1.duration), 64'd50);
      check("ma_gold_rd_run",  64'(b1.gold_rd), 64'd0);
      @(negedge clk);
      check("ma_gold_rd",  64'(b1.gold_rd), 64'd1);
      check("ma_timeout",  64'(b1.timeout), 64'd1);
      repeat (17) @(negedge clk);
      check("ma_finish_early", 64'(b1.finish), 64'd0);
      @(negedge clk);
      check("ma_finish",   64'(b1.finish), 64'd1);
      check("ma_duration", 64'(b1.duration), 64'd50);
      check("ma_error",    64'(b1.error_num), 64'd0);

      // MODE 1 run B: done coincides with duration == TIMEOUT; trigger wins.
      rst1 = 1'b0;
      @(negedge clk);
      rst1 = 1'b1;
      repeat (50) @(negedge clk);
      b1.done = 1'b1;
      @(negedge clk);
      b1.done = 1'b0;
      check("mb_gold_rd",  64'(b1.gold_rd), 64'd1);
      check("mb_timeout",  64'(b1.timeout), 64'd0);
      check("mb_duration", 64'(b1.duration), 64'd50);
      repeat (18) @(negedge clk);
      check("mb_finish",   64'(b1.finish), 64'd1);
      check("mb_timeout_end", 64'(b1.timeout), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/result_checker.md
# result_checker

Parametrised end-of-run checker for the processor testbench. It shadows the data-cache write stream into a DEPTH-word array with byte enables. On end-of-program (PC threshold or explicit done) or watchdog timeout, it walks the array against an external golden ROM through a 1-cycle-latency read port. It reports error count, first failing address, run duration, timeout and late-write flags, then raises finish.

## Interface
- ADDR_W, 8: word-address bits of the checked region; DEPTH = 2**ADDR_W words
- DATA_W, 32: word width; multiple of 8; NB = DATA_W/8 byte lanes
- END_PC, 400: PC threshold for MODE 0
- MODE, 0: 0 = trigger on pc >= END_PC (unsigned); 1 = trigger on done
- TIMEOUT, 250000: watchdog limit in RUN cycles
- CNT_W, 18: duration counter width; must hold TIMEOUT
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- wen  in  1  shadow write strobe
- addr  in  30  word address of write
- wdata  in  DATA_W  write data
- wbe  in  NB  byte enables; bit i covers wdata[8i+7:8i]
- pc  in  32  processor PC (MODE 0)
- done  in  1  end-of-program pulse or level (MODE 1)
- gold_rd  out  1  golden read strobe
- gold_addr  out  ADDR_W  golden read address
- gold_data  in  DATA_W  golden word, valid the cycle after gold_rd
- error_num  out  ADDR_W+1  mismatching words
- first_err_addr  out  ADDR_W  lowest mismatching address
- first_err_vld  out  1  first_err_addr valid
- duration  out  CNT_W  RUN cycles until trigger
- timeout  out  1  check started by watchdog
- late_wr  out  1  sticky: wen seen outside RUN
- finish  out  1  report complete; level

## Operation
- States: RUN (reset state), CHECK, DRAIN, DONE.
- Shadow array: no reset; not initialised by the block. A write is honoured when state is RUN and addr < DEPTH. Only lanes with wbe=1 are updated; addr >= DEPTH is ignored silently. Because reset forces RUN, the bench preloads initial data through wen while rst is low.
- RUN: duration increments each cycle, saturating at 2**CNT_W-1.
  - Trigger (pc >= END_PC in MODE 0, done=1 in MODE 1) -> CHECK.
  - Otherwise, duration == TIMEOUT -> CHECK with timeout<=1.
  - If both occur in the same cycle, trigger wins and timeout stays 0.
  - duration freezes on leaving RUN.
- CHECK: an index i runs 0..DEPTH-1, one per cycle, with gold_rd=1 and gold_addr=i. Compare stage: next cycle, shadow[i_d] !== gold_data (full-word, 4-state) -> error_num+1. The first mismatch latches first_err_addr and sets first_err_vld. After issuing i=DEPTH-1 -> DRAIN.
- DRAIN: final compare completes, gold_rd=0 -> DONE.
- DONE: finish=1, terminal until reset; all outputs hold.
- late_wr is set by wen=1 in CHECK, DRAIN or DONE; that write is discarded.
- error_num cannot overflow: width ADDR_W+1 holds DEPTH.
- Reset mid-check: immediate return to RUN; counters and flags cleared; shadow contents kept.

## Timing
- Reset values: gold_rd 0, gold_addr 0, error_num 0, first_err_addr 0, first_err_vld 0, duration 0, timeout 0, late_wr 0, finish 0.
- A write in the trigger cycle is captured. The trigger is sampled at posedge, so CHECK starts the next cycle.
- Check latency: trigger edge to finish=1 is DEPTH+2 cycles (DEPTH in CHECK, 1 in DRAIN, finish registered entering DONE).
- error_num and first_err_* update one cycle after the corresponding gold_rd and are final when finish rises.
- gold_data is sampled only in the cycle after gold_rd=1 and is otherwise don't-care.

## Test plan
- ADDR_W=8: preload 256 words during reset, apply golden-identical writes, set pc=400 at cycle 1000 -> duration=1000, finish 258 cycles after the trigger edge, error_num=0, first_err_vld=0.
- Corrupt words 5 and 200 via wbe=4'b0010 partial writes -> error_num=2, first_err_addr=5. Untouched lanes keep preload values.
- MODE 1, TIMEOUT=50, done never asserted -> timeout=1, duration=50, check still runs and finish rises.
- Write to addr=256 (ADDR_W=8), then wen after the trigger -> no array change, late_wr=1, error_num unaffected.
- done and duration==TIMEOUT in the same cycle -> timeout=0. Also: assert rst during CHECK at i=100 -> all outputs return to reset values, state RUN; a rerun reports identical results.
